// File: rtl/swervolf_ram_init_if.sv
// AXI4 channel bundle between swervolf_ram_init (master) and the RAM port (slave).
// AR/R channels exist only when SWERVOLF_RAM_INIT_VERIFY_EN is defined.
interface swervolf_ram_init_if #(
    parameter int ID_WIDTH = 6
);
    logic [ID_WIDTH-1:0] o_awid;
    logic [31:0]         o_awaddr;
    logic [7:0]          o_awlen;
    logic [2:0]          o_awsize;
    logic [1:0]          o_awburst;
    logic                o_awvalid;
    logic                i_awready;

    logic [63:0]         o_wdata;
    logic [7:0]          o_wstrb;
    logic                o_wlast;
    logic                o_wvalid;
    logic                i_wready;

    logic [ID_WIDTH-1:0] i_bid;
    logic [1:0]          i_bresp;
    logic                i_bvalid;
    logic                o_bready;

`ifdef SWERVOLF_RAM_INIT_VERIFY_EN
    logic [ID_WIDTH-1:0] o_arid;
    logic [31:0]         o_araddr;
    logic [7:0]          o_arlen;
    logic [2:0]          o_arsize;
    logic [1:0]          o_arburst;
    logic                o_arvalid;
    logic                i_arready;

    logic [ID_WIDTH-1:0] i_rid;
    logic [63:0]         i_rdata;
    logic [1:0]          i_rresp;
    logic                i_rlast;
    logic                i_rvalid;
    logic                o_rready;
`endif

    modport master (
`ifdef SWERVOLF_RAM_INIT_VERIFY_EN
        output o_arid, o_araddr, o_arlen, o_arsize, o_arburst, o_arvalid, o_rready,
        input  i_arready, i_rid, i_rdata, i_rresp, i_rlast, i_rvalid,
`endif
        output o_awid, o_awaddr, o_awlen, o_awsize, o_awburst, o_awvalid,
        output o_wdata, o_wstrb, o_wlast, o_wvalid, o_bready,
        input  i_awready, i_wready, i_bid, i_bresp, i_bvalid
    );

    modport slave (
`ifdef SWERVOLF_RAM_INIT_VERIFY_EN
        input  o_arid, o_araddr, o_arlen, o_arsize, o_arburst, o_arvalid, o_rready,
        output i_arready, i_rid, i_rdata, i_rresp, i_rlast, i_rvalid,
`endif
        input  o_awid, o_awaddr, o_awlen, o_awsize, o_awburst, o_awvalid,
        input  o_wdata, o_wstrb, o_wlast, o_wvalid, o_bready,
        output i_awready, i_wready, i_bid, i_bresp, i_bvalid
    );
endinterface

// File: rtl/swervolf_ram_init.sv
// Writes every RAM word with its own byte address using 16-beat INCR bursts, one at a time.
// Define SWERVOLF_RAM_INIT_VERIFY_EN to add a read-back pass that checks the pattern.
module swervolf_ram_init #(
    parameter int          ID_WIDTH  = 6,
    parameter int unsigned MEM_SIZE  = 32'h100000,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    output logic o_busy,
    output logic o_init_done,
    output logic o_init_error,
    swervolf_ram_init_if.master axi
);
    localparam int NBURST = int'(MEM_SIZE / 128);
    localparam int CW     = $clog2(NBURST + 1);
    localparam logic [CW-1:0] LAST_BURST = CW'(NBURST - 1);

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WDATA,
        WRESP,
`ifdef SWERVOLF_RAM_INIT_VERIFY_EN
        RADDR,
        RDATA,
`endif
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] burst_q, burst_d;
    logic [3:0]    beat_q, beat_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          bready_q, bready_d;
`ifdef SWERVOLF_RAM_INIT_VERIFY_EN
    logic          arvalid_q, arvalid_d;
    logic          rready_q, rready_d;
`endif

    logic [31:0] burst_addr;
    logic [31:0] beat_addr;
    logic [63:0] pattern;

    // Address and data derive from the counters alone, so payloads stay stable under stalls.
    assign burst_addr = BASE_ADDR + (32'(burst_q) << 7);
    assign beat_addr  = burst_addr + {25'd0, beat_q, 3'd0};
    assign pattern    = {beat_addr + 32'd4, beat_addr};

    always_comb begin
        state_d   = state_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        busy_d    = busy_q;
        done_d    = done_q;
        error_d   = error_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
`ifdef SWERVOLF_RAM_INIT_VERIFY_EN
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (i_start) begin
                    state_d   = WADDR;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    burst_d   = '0;
                    beat_d    = '0;
                    awvalid_d = 1'b1;
                end
            end
            WADDR: begin
                if (axi.i_awready) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b1;
                    state_d   = WDATA;
                end
            end
            WDATA: begin
                if (axi.i_wready) begin
                    beat_d = beat_q + 4'd1;
                    if (beat_q == 4'd15) begin
                        wvalid_d = 1'b0;
                        bready_d = 1'b1;
                        state_d  = WRESP;
                    end
                end
            end
            WRESP: begin
                if (axi.i_bvalid) begin
                    bready_d = 1'b0;
                    burst_d  = burst_q + CW'(1);
                    if (axi.i_bresp != 2'b00) error_d = 1'b1;
                    if (burst_q != LAST_BURST) begin
                        awvalid_d = 1'b1;
                        state_d   = WADDR;
                    end else begin
`ifdef SWERVOLF_RAM_INIT_VERIFY_EN
                        burst_d   = '0;
                        arvalid_d = 1'b1;
                        state_d   = RADDR;
`else
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
`endif
                    end
                end
            end
`ifdef SWERVOLF_RAM_INIT_VERIFY_EN
            RADDR: begin
                if (axi.i_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RDATA;
                end
            end
            RDATA: begin
                if (axi.i_rvalid) begin
                    beat_d = beat_q + 4'd1;
                    if ((axi.i_rdata != pattern) || (axi.i_rresp != 2'b00) ||
                        (axi.i_rlast && (beat_q != 4'd15)))
                        error_d = 1'b1;
                    if (beat_q == 4'd15) begin
                        rready_d = 1'b0;
                        burst_d  = burst_q + CW'(1);
                        if (burst_q != LAST_BURST) begin
                            arvalid_d = 1'b1;
                            state_d   = RADDR;
                        end else begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            burst_q   <= '0;
            beat_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
`ifdef SWERVOLF_RAM_INIT_VERIFY_EN
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            burst_q   <= burst_d;
            beat_q    <= beat_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
`ifdef SWERVOLF_RAM_INIT_VERIFY_EN
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
`endif
        end
    end

    assign o_busy       = busy_q;
    assign o_init_done  = done_q;
    assign o_init_error = error_q;

    assign axi.o_awid    = '0;
    assign axi.o_awaddr  = burst_addr;
    assign axi.o_awlen   = 8'd15;
    assign axi.o_awsize  = 3'd3;
    assign axi.o_awburst = 2'b01;
    assign axi.o_awvalid = awvalid_q;
    assign axi.o_wdata   = pattern;
    assign axi.o_wstrb   = 8'hFF;
    assign axi.o_wlast   = wvalid_q && (beat_q == 4'd15);
    assign axi.o_wvalid  = wvalid_q;
    assign axi.o_bready  = bready_q;

    logic unused_ids;
`ifdef SWERVOLF_RAM_INIT_VERIFY_EN
    assign axi.o_arid    = '0;
    assign axi.o_araddr  = burst_addr;
    assign axi.o_arlen   = 8'd15;
    assign axi.o_arsize  = 3'd3;
    assign axi.o_arburst = 2'b01;
    assign axi.o_arvalid = arvalid_q;
    assign axi.o_rready  = rready_q;
    assign unused_ids    = ^{axi.i_bid, axi.i_rid};
`else
    assign unused_ids    = ^axi.i_bid;
`endif
endmodule

// File: tb/tb_swervolf_ram_init.sv
// Randomized scoreboard bench for swervolf_ram_init with a reactive AXI slave model.
// Expected AW/W (and AR) traffic is derived from the address-pattern rule when a run starts.
`timescale 1ns/1ps
module tb_swervolf_ram_init;
    localparam int          ID_WIDTH  = 6;
    localparam int unsigned MEM_SIZE  = 1024;
    localparam logic [31:0] BASE_ADDR = 32'h0;
    localparam int          NBURST    = MEM_SIZE / 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_start = 1'b0;
    logic o_busy, o_init_done, o_init_error;

    swervolf_ram_init_if #(.ID_WIDTH(ID_WIDTH)) axi ();

    swervolf_ram_init #(
        .ID_WIDTH (ID_WIDTH),
        .MEM_SIZE (MEM_SIZE),
        .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .o_busy      (o_busy),
        .o_init_done (o_init_done),
        .o_init_error(o_init_error),
        .axi         (axi)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    logic [31:0] exp_aw[$];
    logic [64:0] exp_w[$];
    logic [31:0] exp_ar[$];
    bit exp_err;
    bit stall_en = 1'b0;
    bit corrupt_en = 1'b0;
    bit err_mask[NBURST];
    int w_beats = 0;
    int aw_count = 0;
    int b_idx = 0;

    task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Builds the whole expected run from the address rule, then pulses start for one cycle.
    task automatic applyStimulus(input int unsigned mask, input bit stall, input bit corrupt);
        logic [31:0] a;
        exp_aw.delete();
        exp_w.delete();
        exp_ar.delete();
        stall_en   = stall;
        corrupt_en = corrupt;
        exp_err    = 1'b0;
        w_beats    = 0;
        aw_count   = 0;
        b_idx      = 0;
        for (int n = 0; n < NBURST; n++) begin
            err_mask[n] = mask[n];
            exp_err |= mask[n];
            exp_aw.push_back(BASE_ADDR + 32'(n * 128));
            exp_ar.push_back(BASE_ADDR + 32'(n * 128));
            for (int b = 0; b < 16; b++) begin
                a = BASE_ADDR + 32'(n * 128 + b * 8);
                exp_w.push_back({b == 15, a + 32'd4, a});
            end
        end
`ifdef SWERVOLF_RAM_INIT_VERIFY_EN
        exp_err |= corrupt;
`endif
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        checkOutput("start_latency", 72'({o_busy, axi.o_awvalid, o_init_done, o_init_error}), 72'(4'b1100));
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (!o_init_done && n < budget) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput("done_reached", 72'(o_init_done), 72'(1'b1));
    endtask

    // Reactive slave: random readies, B after a random delay, optional R read-back.
    initial begin : slave
        bit hs_w_last, hs_b;
        int b_delay;
`ifdef SWERVOLF_RAM_INIT_VERIFY_EN
        bit hs_ar, hs_r, r_active;
        int r_beat;
        logic [31:0] r_addr, ar_addr, a;
        r_active = 1'b0;
        r_beat = 0;
        r_addr = '0;
        axi.i_arready = 1'b0;
        axi.i_rvalid = 1'b0;
        axi.i_rdata = '0;
        axi.i_rresp = 2'b00;
        axi.i_rlast = 1'b0;
        axi.i_rid = '0;
`endif
        b_delay = -1;
        axi.i_awready = 1'b0;
        axi.i_wready = 1'b0;
        axi.i_bvalid = 1'b0;
        axi.i_bresp = 2'b00;
        axi.i_bid = '0;
        forever begin
            @(negedge clk);
            hs_w_last = axi.o_wvalid && axi.i_wready && axi.o_wlast;
            hs_b = axi.i_bvalid && axi.o_bready;
`ifdef SWERVOLF_RAM_INIT_VERIFY_EN
            hs_ar = axi.o_arvalid && axi.i_arready;
            hs_r = axi.i_rvalid && axi.o_rready;
            ar_addr = axi.o_araddr;
`endif
            @(posedge clk); #1;
            axi.i_awready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            axi.i_wready  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (hs_b) axi.i_bvalid = 1'b0;
            if (hs_w_last) b_delay = $urandom_range(0, 3);
            if (b_delay == 0 && !axi.i_bvalid) begin
                axi.i_bvalid = 1'b1;
                axi.i_bresp = err_mask[b_idx % NBURST] ? 2'($urandom_range(1, 3)) : 2'b00;
                b_idx++;
                b_delay = -1;
            end else if (b_delay > 0) begin
                b_delay--;
            end
`ifdef SWERVOLF_RAM_INIT_VERIFY_EN
            axi.i_arready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (hs_r) begin
                axi.i_rvalid = 1'b0;
                if (r_beat == 15) r_active = 1'b0;
                r_beat++;
            end
            if (hs_ar) begin
                r_active = 1'b1;
                r_beat = 0;
                r_addr = ar_addr;
            end
            if (r_active && !axi.i_rvalid && (!stall_en || $urandom_range(0, 1) == 1)) begin
                a = r_addr + 32'(r_beat * 8);
                axi.i_rdata = (corrupt_en && r_addr == BASE_ADDR && r_beat == 3) ? 64'h0 : {a + 32'd4, a};
                axi.i_rlast = (r_beat == 15);
                axi.i_rresp = 2'b00;
                axi.i_rvalid = 1'b1;
            end
            if (!o_busy) begin
                r_active = 1'b0;
                axi.i_rvalid = 1'b0;
            end
`endif
            if (!o_busy) begin
                axi.i_bvalid = 1'b0;
                b_delay = -1;
            end
        end
    end

    // Monitor: pops expectations on every handshake and checks stability under stalls.
    initial begin : monitor
        logic [31:0] aw_hold;
        logic [64:0] w_hold;
        logic [64:0] e;
        bit aw_stall, w_stall, done_prev;
        aw_stall = 1'b0;
        w_stall = 1'b0;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (aw_stall)
                    checkOutput("aw_stable", 72'({axi.o_awvalid, axi.o_awaddr}), 72'({1'b1, aw_hold}));
                if (w_stall)
                    checkOutput("w_stable", 72'({axi.o_wvalid, axi.o_wlast, axi.o_wdata}), 72'({1'b1, w_hold}));
                if (axi.o_awvalid && axi.i_awready) begin
                    e = (exp_aw.size() != 0) ? 65'(exp_aw.pop_front()) : 'x;
                    checkOutput("awaddr", 72'(axi.o_awaddr), 72'(e));
                    checkOutput("aw_const", 72'({axi.o_awid, axi.o_awlen, axi.o_awsize, axi.o_awburst}),
                                72'({ID_WIDTH'(0), 8'd15, 3'd3, 2'b01}));
                    aw_count++;
                end
                if (axi.o_wvalid && axi.i_wready) begin
                    e = (exp_w.size() != 0) ? exp_w.pop_front() : 'x;
                    checkOutput("wbeat", 72'({axi.o_wlast, axi.o_wdata}), 72'(e));
                    checkOutput("wstrb", 72'(axi.o_wstrb), 72'(8'hFF));
                    w_beats++;
                end
`ifdef SWERVOLF_RAM_INIT_VERIFY_EN
                if (axi.o_arvalid && axi.i_arready) begin
                    e = (exp_ar.size() != 0) ? 65'(exp_ar.pop_front()) : 'x;
                    checkOutput("araddr", 72'(axi.o_araddr), 72'(e));
                end
`endif
                if (o_init_done && !done_prev) begin
                    checkOutput("done_error", 72'(o_init_error), 72'(exp_err));
                    checkOutput("done_busy", 72'(o_busy), 72'(1'b0));
                    checkOutput("done_drained", 72'(exp_aw.size() + exp_w.size()), 72'(0));
                end
            end
            aw_stall = !rst && axi.o_awvalid && !axi.i_awready;
            aw_hold = axi.o_awaddr;
            w_stall = !rst && axi.o_wvalid && !axi.i_wready;
            w_hold = {axi.o_wlast, axi.o_wdata};
            done_prev = o_init_done;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : main
        int n;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_state", 72'({o_busy, o_init_done, o_init_error, axi.o_awvalid, axi.o_wvalid, axi.o_bready}), 72'(0));
        rst = 1'b0;

        $display("[TB] clean run, always-ready slave");
        applyStimulus(0, 1'b0, 1'b0);
        waitDone(5000);
        checkOutput("clean_flags", 72'({o_init_done, o_init_error}), 72'(2'b10));
        checkOutput("clean_beats", 72'(w_beats), 72'(NBURST * 16));
        checkOutput("clean_bursts", 72'(aw_count), 72'(NBURST));
        repeat (5) @(posedge clk);
        #1 checkOutput("done_sticky", 72'({o_busy, o_init_done}), 72'(2'b01));

        $display("[TB] random stalls");
        applyStimulus(0, 1'b1, 1'b0);
        waitDone(5000);
        checkOutput("stall_flags", 72'({o_init_done, o_init_error}), 72'(2'b10));
        checkOutput("stall_beats", 72'(w_beats), 72'(NBURST * 16));

        $display("[TB] error response on first burst");
        applyStimulus(1, 1'b0, 1'b0);
        waitDone(5000);
        checkOutput("berr_flags", 72'({o_init_done, o_init_error}), 72'(2'b11));
        checkOutput("berr_bursts", 72'(aw_count), 72'(NBURST));

        for (int r = 0; r < 3; r++) begin
            applyStimulus($urandom_range(0, 255) & $urandom_range(0, 255) & $urandom_range(0, 255), 1'b1, 1'b0);
            waitDone(5000);
            checkOutput("rand_error", 72'(o_init_error), 72'(exp_err));
        end

`ifdef SWERVOLF_RAM_INIT_VERIFY_EN
        $display("[TB] read-back with corrupted beat");
        applyStimulus(0, 1'b0, 1'b1);
        waitDone(10000);
        checkOutput("verify_flags", 72'({o_init_done, o_init_error}), 72'(2'b11));
        corrupt_en = 1'b0;
`endif

        $display("[TB] start pulse while busy");
        applyStimulus(0, 1'b0, 1'b0);
        n = 0;
        while (w_beats < 20 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        checkOutput("busy_start_ignored", 72'({o_busy, o_init_done}), 72'(2'b10));
        waitDone(5000);
        checkOutput("busy_start_beats", 72'(w_beats), 72'(NBURST * 16));

        $display("[TB] reset during beat 7 of burst 2");
        applyStimulus(0, 1'b0, 1'b0);
        n = 0;
        while (w_beats < 2 * 16 + 7 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reached_beat7", 72'(w_beats), 72'(2 * 16 + 7));
        @(posedge clk); #1 rst = 1'b1;
        exp_aw.delete();
        exp_w.delete();
        exp_ar.delete();
        @(posedge clk); #1;
        checkOutput("midrun_reset", 72'({o_busy, o_init_done, o_init_error, axi.o_awvalid,
                                         axi.o_wvalid, axi.o_wlast, axi.o_bready}), 72'(0));
        rst = 1'b0;
        applyStimulus(0, 1'b1, 1'b0);
        waitDone(5000);
        checkOutput("restart_flags", 72'({o_init_done, o_init_error}), 72'(2'b10));
        checkOutput("restart_beats", 72'(w_beats), 72'(NBURST * 16));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
